// File: rtl/divider_n_bits.sv
// ============================================================================
// Module   : divider_n_bits
// Brief    : Sequential unsigned N-bit restoring divider, one quotient bit per
//            clock, with start/busy/done handshake and divide-by-zero flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module divider_n_bits #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         aclr,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         busy,
    output logic         done,
    output logic         div_zero
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] C_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N:0]    p_q, p_d;
    logic [N-1:0]  d_q, d_d;
    logic [N-1:0]  bq_q, bq_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  r_q, r_d;
    logic          dz_q, dz_d;

    logic [N:0]    w_shifted;
    logic [N+1:0]  w_trial;
    logic          w_accept;

    // The partial remainder always stays below the divisor, so p_q[N] is zero;
    // carrying it into the trial keeps the borrow in the extra top bit.
    assign w_shifted = {p_q[N-1:0], d_q[N-1]};
    assign w_trial   = {p_q, d_q[N-1]} - {2'b00, bq_q};
    assign w_accept  = (state_q != RUN) && start;

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        d_d     = d_q;
        bq_d    = bq_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dz_d    = dz_q;

        case (state_q)
            RUN: begin
                if (!w_trial[N+1]) begin
                    p_d = w_trial[N:0];
                    d_d = {d_q[N-2:0], 1'b1};
                end else begin
                    p_d = w_shifted;
                    d_d = {d_q[N-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST) begin
                    state_d = FIN;
                    q_d     = d_d;
                    r_d     = p_d[N-1:0];
                    dz_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                if (w_accept) begin
                    p_d   = '0;
                    d_d   = A;
                    bq_d  = B;
                    cnt_d = '0;
                    if (B != '0) begin
                        state_d = RUN;
                    end else begin
                        // Divide by zero resolves immediately without iterating.
                        state_d = FIN;
                        q_d     = '1;
                        r_d     = A;
                        dz_d    = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q <= IDLE;
            p_q     <= '0;
            d_q     <= '0;
            bq_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            d_q     <= d_d;
            bq_q    <= bq_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dz_q    <= dz_d;
        end
    end

    assign Q        = q_q;
    assign R        = r_q;
    assign div_zero = dz_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == FIN);

endmodule

`default_nettype wire

// File: tb/tb_divider_n_bits.sv
// ============================================================================
// Module   : tb_divider_n_bits
// Brief    : Self-checking directed bench for divider_n_bits (N = 8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_divider_n_bits;

    localparam int N = 8;

    logic         clk;
    logic         aclr;
    logic         start;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic [N-1:0] q_out;
    logic [N-1:0] r_out;
    logic         busy;
    logic         done;
    logic         div_zero;

    int checks   = 0;
    int failures = 0;

    divider_n_bits #(.N(N)) dut (
        .clk      (clk),
        .aclr     (aclr),
        .start    (start),
        .A        (a_in),
        .B        (b_in),
        .Q        (q_out),
        .R        (r_out),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
        end
    endtask

    // Issue one division, wait for done, and check latency, busy length and results.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] eq, input logic [7:0] er, input logic edz,
                          input int elat);
        int lat;
        int busy_cnt;
        lat      = 0;
        busy_cnt = 0;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_latency"}, lat, elat);
        check_eq({tag, "_busy_cycles"}, busy_cnt, (b == 8'd0) ? 0 : N);
        check_eq({tag, "_Q"}, q_out, eq);
        check_eq({tag, "_R"}, r_out, er);
        check_eq({tag, "_div_zero"}, div_zero, edz);
        @(posedge clk);
        #1;
        check_eq({tag, "_done_width"}, done, 1'b0);
    endtask

    initial begin : main
        int ndone;
        int first_edge;
        int second_edge;
        logic [7:0] cap_q [2];
        logic [7:0] cap_r [2];
        logic pending_drop;
        logic [7:0] sa;
        logic [7:0] sb;

        aclr  = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #12;
        check_eq("reset_Q", q_out, 8'd0);
        check_eq("reset_R", r_out, 8'd0);
        check_eq("reset_busy", busy, 1'b0);
        check_eq("reset_done", done, 1'b0);
        check_eq("reset_div_zero", div_zero, 1'b0);
        @(negedge clk);
        aclr = 1'b0;

        run_op("div_200_7",   8'd200, 8'd7,   8'd28,  8'd4,   1'b0, N);
        run_op("div_255_1",   8'd255, 8'd1,   8'd255, 8'd0,   1'b0, N);
        run_op("div_5_9",     8'd5,   8'd9,   8'd0,   8'd5,   1'b0, N);
        run_op("div_0_200",   8'd0,   8'd200, 8'd0,   8'd0,   1'b0, N);
        run_op("div_255_255", 8'd255, 8'd255, 8'd1,   8'd0,   1'b0, N);
        run_op("div_by_zero", 8'h37,  8'd0,   8'hFF,  8'h37,  1'b1, 0);
        run_op("div_9_3",     8'd9,   8'd3,   8'd3,   8'd0,   1'b0, N);

        // Start while busy: a second request on RUN cycle 3 must be ignored.
        @(negedge clk);
        a_in  = 8'd100;
        b_in  = 8'd10;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        cap_q[0] = '0;
        cap_r[0] = '0;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) begin
                a_in  = 8'd50;
                b_in  = 8'd5;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                cap_q[0] = q_out;
                cap_r[0] = r_out;
            end
        end
        check_eq("busy_start_done_count", ndone, 1);
        check_eq("busy_start_Q", cap_q[0], 8'd10);
        check_eq("busy_start_R", cap_r[0], 8'd0);

        // Back-to-back: start held through FIN with new operands.
        @(negedge clk);
        a_in  = 8'd77;
        b_in  = 8'd5;
        start = 1'b1;
        ndone = 0;
        first_edge  = -1;
        second_edge = -1;
        pending_drop = 1'b0;
        cap_q[1] = '0;
        cap_r[1] = '0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (pending_drop) begin
                start = 1'b0;
                pending_drop = 1'b0;
            end
            if (done) begin
                if (ndone < 2) begin
                    cap_q[ndone] = q_out;
                    cap_r[ndone] = r_out;
                end
                if (ndone == 0) begin
                    first_edge = i;
                    a_in = 8'd13;
                    b_in = 8'd4;
                    pending_drop = 1'b1;
                end else if (ndone == 1) begin
                    second_edge = i;
                end
                ndone++;
            end
        end
        start = 1'b0;
        check_eq("b2b_done_count", ndone, 2);
        check_eq("b2b_first_Q", cap_q[0], 8'd15);
        check_eq("b2b_first_R", cap_r[0], 8'd2);
        check_eq("b2b_second_Q", cap_q[1], 8'd3);
        check_eq("b2b_second_R", cap_r[1], 8'd1);
        check_eq("b2b_spacing", second_edge - first_edge, N + 1);

        // Asynchronous reset on RUN cycle 4 of 200/7.
        @(negedge clk);
        a_in  = 8'd200;
        b_in  = 8'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check_eq("pre_abort_busy", busy, 1'b1);
        aclr = 1'b1;
        #1;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_done", done, 1'b0);
        check_eq("abort_Q", q_out, 8'd0);
        check_eq("abort_R", r_out, 8'd0);
        @(negedge clk);
        aclr  = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check_eq("abort_no_done", ndone, 0);
        check_eq("abort_Q_hold", q_out, 8'd0);
        run_op("after_abort_200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, N);

        // Sampled sweep: exact quotient/remainder and the division invariant.
        for (int k = 0; k < 300; k++) begin
            sa = (k < 8) ? 8'(k * 37) : 8'($urandom_range(0, 255));
            sb = 8'($urandom_range(1, 255));
            if (k % 50 == 0) sb = 8'd1;
            @(negedge clk);
            a_in  = sa;
            b_in  = sb;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            begin
                int lat;
                lat = 0;
                while (!done && lat < 40) begin
                    @(posedge clk);
                    #1;
                    lat++;
                end
                check_eq("sweep_latency", lat, N);
            end
            check_eq("sweep_Q", q_out, sa / sb);
            check_eq("sweep_R", r_out, sa % sb);
            check_eq("sweep_invariant", (32'(q_out) * 32'(sb) + 32'(r_out) == 32'(sa)) && (r_out < sb), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
